// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instr_fetch_queue_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam logic [PC_W-1:0] PC_STEP    = 32'd4;
    localparam logic [PC_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    // One queue slot: an instruction word tagged with its fetch address.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    // Force a redirect target onto a word boundary.
    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] pc);
        return pc & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/instr_fetch_queue_rom.sv
// Instruction RAM with one-cycle registered read. Contents are never reset,
// so a preload survives a mid-run reset. The write port exists for loading
// and is tied off by the fetch queue.
module instr_rom
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 256,
    parameter int unsigned AW        = $clog2(RAM_WORDS)
) (
    input  logic               clock,
    input  logic               rd_en_i,
    input  logic [AW-1:0]      rd_idx_i,
    output logic [INSTR_W-1:0] rd_data_o,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      wr_idx_i,
    input  logic [INSTR_W-1:0] wr_data_i
);

    logic [INSTR_W-1:0] memory [RAM_WORDS];
    logic [INSTR_W-1:0] rd_data_q;

    // Synchronous write and registered read of the word array.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            memory[wr_idx_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= memory[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: sequential fetch from a 1-cycle RAM into a
// 2-entry FIFO, with redirect flushing both queue and in-flight read.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned       RAM_WORDS = 256,
    parameter logic [PC_W-1:0]   RESET_PC  = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    fq_entry_t [1:0]    slot_q;

    logic               pop;
    logic               push;
    logic               issue;
    logic [2:0]         occupancy;
    logic [INSTR_W-1:0] rom_data;
    fq_entry_t          head;

    instr_rom #(
        .RAM_WORDS (RAM_WORDS),
        .AW        (AW)
    ) u_rom (
        .clock     (clock),
        .rd_en_i   (issue),
        .rd_idx_i  (fetch_pc_q[AW+1:2]),
        .rd_data_o (rom_data),
        .wr_en_i   (1'b0),
        .wr_idx_i  ('0),
        .wr_data_i ('0)
    );

    // Transfer, push, issue and next-state decisions; a redirect suppresses
    // both the push of the returning read and any new issue this cycle.
    always_comb begin
        pop           = (count_q != 2'd0) && out_ready;
        push          = inflight_q && !redirect_valid;
        occupancy     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue         = !redirect_valid && (occupancy < 3'd2);

        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;

        if (redirect_valid) begin
            count_d    = 2'd0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            fetch_pc_d = pc_align(redirect_pc);
        end else begin
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            wr_ptr_d = wr_ptr_q ^ push;
            rd_ptr_d = rd_ptr_q ^ pop;
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + PC_STEP;
                inflight_pc_d = fetch_pc_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Queue storage: capture the returning RAM word with its address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_q <= '0;
        end else if (push) begin
            slot_q[wr_ptr_q] <= '{pc: inflight_pc_q, instr: rom_data};
        end
    end

    // Head presentation; stale slot contents are masked when empty.
    always_comb begin
        head      = slot_q[rd_ptr_q];
        out_valid = (count_q != 2'd0);
        out_pc    = out_valid ? head.pc    : '0;
        out_instr = out_valid ? head.instr : '0;
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a
// randomized run against a stream-level reference model.
module tb_instr_fetch_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    logic        b_reset;
    logic        b_redirect_valid;
    logic [31:0] b_redirect_pc;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [31:0] b_out_instr;
    logic [31:0] b_out_pc;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_model [256];

    instr_fetch_queue #(
        .RAM_WORDS (256),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    instr_fetch_queue #(
        .RAM_WORDS (256),
        .RESET_PC  (32'hFFFF_FFF8)
    ) dut_wrap (
        .clock          (clock),
        .reset          (b_reset),
        .redirect_valid (b_redirect_valid),
        .redirect_pc    (b_redirect_pc),
        .out_valid      (b_out_valid),
        .out_ready      (b_out_ready),
        .out_instr      (b_out_instr),
        .out_pc         (b_out_pc)
    );

    always #5 clock = ~clock;

    task automatic set_word(input int unsigned idx, input logic [31:0] val);
        mem_model[idx] = val;
        dut.u_rom.memory[idx] = val;
    endtask

    // Expected word for a fetch address: word index modulo the RAM depth.
    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return mem_model[(pc / 4) % 256];
    endfunction

    // Hold reset for two edges, release at a falling edge; the next rising
    // edge is edge 1.
    task automatic apply_reset(input logic ready);
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = ready;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_pc !== 32'h0) begin
            errors++; $display("FAIL reset_pc: got %h expected 00000000", out_pc);
        end
        checks++;
        if (out_instr !== 32'h0) begin
            errors++; $display("FAIL reset_instr: got %h expected 00000000", out_instr);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_out_pc !== 32'h0) begin
            errors++; $display("FAIL reset_wrap_dut: got valid %b pc %h expected 0 00000000", b_out_valid, b_out_pc);
        end
    endtask

    task automatic test_stream;
        set_word(0, 32'h11); set_word(1, 32'h22); set_word(2, 32'h33); set_word(3, 32'h44);
        apply_reset(1'b1);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_edge1_valid: got %b expected 0", out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== word_at(32'(4 * k))) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         k, out_valid, out_pc, out_instr, 32'(4 * k), word_at(32'(4 * k)));
            end
        end
    endtask

    task automatic test_stall;
        apply_reset(1'b0);
        @(negedge clock);
        @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h11) begin
                errors++;
                $display("FAIL stall_hold_%0d: got v=%b pc=%h instr=%h expected v=1 pc=00000000 instr=00000011",
                         k, out_valid, out_pc, out_instr);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== word_at(32'(4 * k))) begin
                errors++;
                $display("FAIL stall_drain_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         k, out_valid, out_pc, out_instr, 32'(4 * k), word_at(32'(4 * k)));
            end
        end
    endtask

    task automatic test_redirect_full;
        for (int unsigned i = 0; i < 64; i++) set_word(i, 32'hA000_0000 + i);
        apply_reset(1'b0);
        repeat (4) @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            errors++; $display("FAIL redir_prefull: got v=%b pc=%h expected v=1 pc=00000000", out_valid, out_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h13;
        @(negedge clock);
        redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL redir_flushed_%0d: got v=%b pc=%h expected v=0", k, out_valid, out_pc);
            end
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== word_at(32'h10)) begin
            errors++;
            $display("FAIL redir_target: got v=%b pc=%h instr=%h expected v=1 pc=00000010 instr=%h",
                     out_valid, out_pc, out_instr, word_at(32'h10));
        end
    endtask

    task automatic test_back_to_back;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clock);
        redirect_pc    = 32'h86;
        @(negedge clock);
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_gap0: got v=%b pc=%h expected v=0", out_valid, out_pc);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_gap1: got v=%b pc=%h expected v=0", out_valid, out_pc);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(32'h84 + 4 * k) || out_instr !== word_at(32'(32'h84 + 4 * k))) begin
                errors++;
                $display("FAIL b2b_stream_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         k, out_valid, out_pc, out_instr, 32'(32'h84 + 4 * k), word_at(32'(32'h84 + 4 * k)));
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
        exp_in[0] = 32'hCAFE_00FE; exp_in[1] = 32'hCAFE_00FF; exp_in[2] = 32'hCAFE_0000;
        dut_wrap.u_rom.memory[254] = exp_in[0];
        dut_wrap.u_rom.memory[255] = exp_in[1];
        dut_wrap.u_rom.memory[0]   = exp_in[2];
        b_out_ready = 1'b1;
        @(negedge clock);
        b_reset = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (b_out_valid !== 1'b1 || b_out_pc !== exp_pc[k] || b_out_instr !== exp_in[k]) begin
                errors++;
                $display("FAIL wrap_%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         k, b_out_valid, b_out_pc, b_out_instr, exp_pc[k], exp_in[k]);
            end
        end
    endtask

    task automatic test_async_reset;
        apply_reset(1'b1);
        repeat (5) @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got v=%b expected 1", out_valid);
        end
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
            errors++;
            $display("FAIL areset_immediate: got v=%b pc=%h instr=%h expected v=0 pc=00000000 instr=00000000",
                     out_valid, out_pc, out_instr);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL areset_edge1: got v=%b expected 0", out_valid);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== word_at(32'h0)) begin
            errors++;
            $display("FAIL areset_refetch: got v=%b pc=%h instr=%h expected v=1 pc=00000000 instr=%h",
                     out_valid, out_pc, out_instr, word_at(32'h0));
        end
    endtask

    // Reference: the presented stream is the sequential word stream starting
    // at the last reset/redirect target; valid is low for exactly two edges
    // after such a restart and high from then on.
    task automatic test_random;
        logic [31:0] exp_pc;
        int          since;
        logic        exp_valid;
        logic        fire;
        for (int unsigned i = 0; i < 256; i++) set_word(i, $urandom);
        apply_reset(1'b1);
        exp_pc = 32'h0;
        since  = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            exp_valid = (since >= 2);
            checks++;
            if (out_valid !== exp_valid) begin
                errors++; $display("FAIL rand_valid@%0d: got %b expected %b", cyc, out_valid, exp_valid);
            end
            if (exp_valid) begin
                checks++;
                if (out_pc !== exp_pc || out_instr !== word_at(exp_pc)) begin
                    errors++;
                    $display("FAIL rand_head@%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                             cyc, out_pc, out_instr, exp_pc, word_at(exp_pc));
                end
            end
            fire = exp_valid && out_ready;
            @(posedge clock);
            if (redirect_valid) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
                since  = 0;
            end else begin
                if (fire) exp_pc = exp_pc + 32'd4;
                if (since < 2) since++;
            end
            #1;
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;
            @(negedge clock);
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        out_ready        = 1'b0;
        b_reset          = 1'b0;
        b_redirect_valid = 1'b0;
        b_redirect_pc    = '0;
        b_out_ready      = 1'b0;

        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 256, meaning instruction RAM depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have port clock, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning the reset: asynchronous and active-low.
REQ-005 The block SHALL have port redirect_valid, input, 1, meaning a branch/jump redirect request this cycle.
REQ-006 The block SHALL have port redirect_pc, input, 32, meaning the redirect target.
REQ-007 The block SHALL have port out_valid, output, 1, meaning the head entry is valid for decode.
REQ-008 The block SHALL have port out_ready, input, 1, meaning decode accepts the head entry.
REQ-009 The block SHALL have port out_instr, output, 32, meaning the head instruction word.
REQ-010 The block SHALL have port out_pc, output, 32, meaning the head instruction's address.

Function
REQ-011 The block SHALL transfer an entry on a rising edge only when out_valid and out_ready are both high; out_instr and out_pc SHALL hold stable while out_valid is high and out_ready is low.
REQ-012 The block SHALL hold fetch_pc (32 bits) and issue one RAM read per cycle at word index fetch_pc[log2(RAM_WORDS)+1:2]; the index wraps modulo RAM_WORDS.
REQ-013 The instruction RAM SHALL have a read latency of 1 cycle: the word read at edge N is pushed into the queue at edge N+1, tagged with its PC.
REQ-014 The queue SHALL be a 2-entry FIFO; a read SHALL issue only if count + inflight - pop < 2, where pop is this cycle's transfer and inflight is 0 or 1.
REQ-015 Each issued read SHALL advance fetch_pc by 4; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-016 With out_ready held high, the block SHALL sustain 1 instruction per cycle after the first.
REQ-017 First-fetch latency SHALL be fixed: out_valid rises after the 2nd rising edge following reset deassertion, when the queue holds RESET_PC's word.
REQ-018 On a redirect_valid cycle:
- a transfer on that edge SHALL complete normally;
- all other queue entries SHALL be discarded;
- any in-flight read result SHALL be discarded;
- fetch_pc SHALL load {redirect_pc[31:2],2'b00}.
REQ-019 After a redirect, the first issue SHALL occur on the edge after the redirect edge; out_valid for the target SHALL rise 2 edges after the redirect edge.
REQ-020 A redirect while the queue is full and out_ready is low SHALL still flush; no stale entry SHALL ever be presented.
REQ-021 Back-to-back redirects SHALL be honoured: the last one wins.
REQ-022 Queue pointers SHALL wrap modulo 2; the queue SHALL never overflow or underflow.

Reset
REQ-023 While reset is low:
- fetch_pc = RESET_PC;
- count = 0, inflight = 0, pointers = 0;
- out_valid = 0; out_instr and out_pc = 0.
REQ-024 Reset asserted mid-operation SHALL clear state immediately; RAM contents SHALL be preserved.

Structure
REQ-025 A shared package SHALL hold INSTR_W=32, PC_W=32, PC_STEP=4 and the queue-entry type {pc, instr}.
REQ-026 The RAM SHALL be a sub-module instr_rom with an internal array named memory, so benches can preload it with $readmemh via hierarchy.

Verification
REQ-027 Scenario: preload words 0..3 = 11,22,33,44, RESET_PC=0, out_ready=1 -> out_instr 11,22,33,44 on consecutive cycles; out_pc 0,4,8,C; first valid at edge 2.
REQ-028 Scenario: out_ready=0 for 5 cycles after first valid -> head stays pc 0/11; then out_ready=1 -> 11,22,33 in order with no loss or duplication.
REQ-029 Scenario: redirect_valid with redirect_pc=0x13 while the queue is full -> the flushed entries never appear; next valid is pc 0x10, 2 edges later.
REQ-030 Scenario: RESET_PC=0xFFFF_FFF8, RAM_WORDS=256 -> out_pc FFFFFFF8, FFFFFFFC, 00000000; indices 254, 255, 0.
REQ-031 Scenario: reset driven low mid-stream with out_valid=1 -> out_valid=0 without a clock edge; after release, refetch from RESET_PC with the REQ-017 latency.
